// File: rtl/pcs_pkg.sv
// Constants and types shared by the PCS receive path: K28.5 comma codes,
// the symbol-sync state encoding and the lock/unlock thresholds.
package pcs_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } sync_state_t;

  localparam logic [1:0] GOOD_THRESH  = 2'd3;
  localparam logic [2:0] ERR_THRESH   = 3'd4;
  localparam logic [5:0] WORD_TIMEOUT = 6'd63;

  function automatic logic is_k28_5(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/rx_comma_detect.sv
// Combinational K28.5 matcher on a 10-bit window (bit0 = first received bit).
module rx_comma_detect
  import pcs_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_match
);

  assign o_match = is_k28_5(i_sym);

endmodule

// File: rtl/rx_word_aligner.sv
// Serial-to-10b word aligner: shifts in recovered bits, realigns on K28.5
// commas and tracks symbol lock with a good/error/timeout sync machine.
module rx_word_aligner
  import pcs_pkg::*;
(
  input  logic       CLK_5G,
  input  logic       RST_n,
  input  logic       Serial_In,
  input  logic       Align_En,
  output logic [9:0] Collected_Data,
  output logic       Word_Valid,
  output logic       Comma_Det,
  output logic       Symbol_Lock
);

  logic [9:0]  r_sr;
  logic [3:0]  r_bcnt;
  logic [9:0]  r_data;
  logic        r_valid;
  logic        r_comma;
  logic        r_lock;

  sync_state_t r_state;
  sync_state_t w_state_next;
  logic [1:0]  r_gcnt, w_gcnt_next, w_gcnt_inc;
  logic [2:0]  r_ecnt, w_ecnt_next, w_ecnt_inc;
  logic [5:0]  r_wcnt, w_wcnt_next, w_wcnt_inc;

  logic        w_match;
  logic        w_boundary;
  logic        w_aligned;
  logic        w_misaligned;
  logic        w_realign;
  logic        w_load;

  rx_comma_detect u_comma_detect (
    .i_sym   (r_sr),
    .o_match (w_match)
  );

  assign w_boundary   = (r_bcnt == 4'd9);
  assign w_aligned    = w_match & w_boundary;
  assign w_misaligned = w_match & ~w_boundary;
  assign w_load       = w_boundary | w_realign;

  assign w_gcnt_inc = r_gcnt + 2'd1;
  assign w_ecnt_inc = r_ecnt + 3'd1;
  assign w_wcnt_inc = r_wcnt + 6'd1;

  always_ff @(posedge CLK_5G or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // With Align_En low everything below keeps its default, i.e. holds.
  always_comb begin
    w_state_next = r_state;
    w_gcnt_next  = r_gcnt;
    w_ecnt_next  = r_ecnt;
    w_wcnt_next  = r_wcnt;
    w_realign    = 1'b0;
    if (Align_En) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_match) begin
            w_realign    = 1'b1;
            w_gcnt_next  = 2'd1;
            w_wcnt_next  = 6'd0;
            w_state_next = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_aligned) begin
            w_wcnt_next = 6'd0;
            w_gcnt_next = w_gcnt_inc;
            if (w_gcnt_inc == GOOD_THRESH) begin
              w_ecnt_next  = 3'd0;
              w_state_next = ST_LOCKED;
            end
          end else if (w_misaligned) begin
            w_realign   = 1'b1;
            w_gcnt_next = 2'd1;
            w_wcnt_next = 6'd0;
          end else if (w_boundary) begin
            w_wcnt_next = w_wcnt_inc;
            if (w_wcnt_inc == WORD_TIMEOUT) begin
              w_wcnt_next  = 6'd0;
              w_gcnt_next  = 2'd0;
              w_state_next = ST_UNLOCKED;
            end
          end
        end
        ST_LOCKED: begin
          // Once locked, stray commas are counted as errors, never realigned on.
          if (w_misaligned) begin
            w_ecnt_next = w_ecnt_inc;
            if (w_ecnt_inc == ERR_THRESH) begin
              w_ecnt_next  = 3'd0;
              w_gcnt_next  = 2'd0;
              w_state_next = ST_UNLOCKED;
            end
          end else if (w_aligned) begin
            w_ecnt_next = 3'd0;
          end
        end
        default: begin
          w_state_next = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_5G or negedge RST_n) begin
    if (!RST_n) begin
      r_sr    <= 10'h000;
      r_bcnt  <= 4'd0;
      r_gcnt  <= 2'd0;
      r_ecnt  <= 3'd0;
      r_wcnt  <= 6'd0;
      r_data  <= 10'h000;
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_sr    <= {Serial_In, r_sr[9:1]};
      r_bcnt  <= w_load ? 4'd0 : r_bcnt + 4'd1;
      r_gcnt  <= w_gcnt_next;
      r_ecnt  <= w_ecnt_next;
      r_wcnt  <= w_wcnt_next;
      r_valid <= w_load;
      r_comma <= w_load & w_match;
      r_lock  <= (w_state_next == ST_LOCKED);
      if (w_load) begin
        r_data <= r_sr;
      end
    end
  end

  assign Collected_Data = r_data;
  assign Word_Valid     = r_valid;
  assign Comma_Det      = r_comma;
  assign Symbol_Lock    = r_lock;

endmodule
